// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - priority bus multiplexer with hold, conflict tracking and ownership FSM
module bus_arb_mux #(
    parameter int WIDTH      = 32,
    parameter int N_SRC      = 25,
    parameter int IDX_W      = 5,
    parameter bit HOLD_EMPTY = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_out,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       bus_out,
    output logic [IDX_W-1:0]       sel_idx,
    output logic                   sel_valid,
    output logic [WIDTH-1:0]       bus_q,
    output logic                   bus_q_valid,
    output logic                   owner_change,
    output logic                   conflict,
    output logic                   conflict_sticky,
    output logic [CNT_W-1:0]       conflict_cnt,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_CONTEND = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_hold_q;
    logic [WIDTH-1:0]   r_bus_q;
    logic               r_bus_q_valid;
    logic               r_owner_change;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_prev_idx;
    logic               r_prev_valid;

    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_win_data;
    logic               w_any;
    logic               w_multi;
    logic [WIDTH-1:0]   w_bus;
    logic [CNT_W-1:0]   w_cnt_base;

    // Ascending scan: the last enabled source seen is the highest index, so it wins.
    always_comb begin
        w_idx      = '0;
        w_win_data = '0;
        w_any      = 1'b0;
        w_multi    = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_out[i]) begin
                if (w_any) w_multi = 1'b1;
                w_any      = 1'b1;
                w_idx      = IDX_W'(i);
                w_win_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_bus = '0;
        if (w_any)           w_bus = w_win_data;
        else if (HOLD_EMPTY) w_bus = r_hold_q;
    end

    // Clear takes effect before the current cycle's conflict is recorded.
    assign w_cnt_base = err_clr ? '0 : r_cnt;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state        <= ST_IDLE;
            r_hold_q       <= '0;
            r_bus_q        <= '0;
            r_bus_q_valid  <= 1'b0;
            r_owner_change <= 1'b0;
            r_sticky       <= 1'b0;
            r_cnt          <= '0;
            r_prev_idx     <= '0;
            r_prev_valid   <= 1'b0;
        end else begin
            if (w_any) r_hold_q <= w_bus;
            r_bus_q        <= w_bus;
            r_bus_q_valid  <= w_any;
            r_owner_change <= w_any & r_prev_valid & (w_idx != r_prev_idx);
            r_prev_idx     <= w_idx;
            r_prev_valid   <= w_any;
            r_sticky       <= (err_clr ? 1'b0 : r_sticky) | w_multi;
            if (w_multi && (w_cnt_base != {CNT_W{1'b1}}))
                r_cnt <= w_cnt_base + 1'b1;
            else
                r_cnt <= w_cnt_base;
            case (r_state)
                ST_IDLE:    r_state <= w_multi ? ST_CONTEND : (w_any ? ST_OWNED : ST_IDLE);
                ST_OWNED:   r_state <= w_multi ? ST_CONTEND : (w_any ? ST_OWNED : ST_IDLE);
                ST_CONTEND: r_state <= w_multi ? ST_CONTEND : (w_any ? ST_OWNED : ST_IDLE);
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_out         = w_bus;
    assign sel_idx         = w_idx;
    assign sel_valid       = w_any;
    assign conflict        = w_multi;
    assign bus_q           = r_bus_q;
    assign bus_q_valid     = r_bus_q_valid;
    assign owner_change    = r_owner_change;
    assign conflict_sticky = r_sticky;
    assign conflict_cnt    = r_cnt;
    assign state           = r_state;

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb/tb_bus_arb_mux.sv - directed self-checking bench for bus_arb_mux
module tb_bus_arb_mux;

    localparam int WIDTH = 32;
    localparam int N_SRC = 25;
    localparam int IDX_W = 5;

    logic                   clk = 1'b0;
    logic                   clr_n;
    logic [N_SRC*WIDTH-1:0] src_data;
    logic [N_SRC-1:0]       src_out;
    logic                   err_clr;

    logic [WIDTH-1:0] bus_out,  bus_q,  n_bus_out,  n_bus_q,  s_bus_out,  s_bus_q;
    logic [IDX_W-1:0] sel_idx,  n_sel_idx,  s_sel_idx;
    logic             sel_valid, bus_q_valid, owner_change, conflict, sticky;
    logic             n_sel_valid, n_bus_q_valid, n_owner_change, n_conflict, n_sticky;
    logic             s_sel_valid, s_bus_q_valid, s_owner_change, s_conflict, s_sticky;
    logic [7:0]       cnt, n_cnt;
    logic [1:0]       s_cnt;
    logic [1:0]       state, n_state, s_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arb_mux u_dut (
        .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
        .bus_out(bus_out), .sel_idx(sel_idx), .sel_valid(sel_valid), .bus_q(bus_q),
        .bus_q_valid(bus_q_valid), .owner_change(owner_change), .conflict(conflict),
        .conflict_sticky(sticky), .conflict_cnt(cnt), .state(state)
    );

    bus_arb_mux #(.HOLD_EMPTY(1'b0)) u_noh (
        .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
        .bus_out(n_bus_out), .sel_idx(n_sel_idx), .sel_valid(n_sel_valid), .bus_q(n_bus_q),
        .bus_q_valid(n_bus_q_valid), .owner_change(n_owner_change), .conflict(n_conflict),
        .conflict_sticky(n_sticky), .conflict_cnt(n_cnt), .state(n_state)
    );

    bus_arb_mux #(.CNT_W(2)) u_sat (
        .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
        .bus_out(s_bus_out), .sel_idx(s_sel_idx), .sel_valid(s_sel_valid), .bus_q(s_bus_q),
        .bus_q_valid(s_bus_q_valid), .owner_change(s_owner_change), .conflict(s_conflict),
        .conflict_sticky(s_sticky), .conflict_cnt(s_cnt), .state(s_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; src_out = '1; err_clr = 1'b0;
        step(); step();
        n_cmp++; if (bus_q !== 32'h0) begin n_err++; $display("FAIL rst_bus_q got %h exp 0", bus_q); end
        n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
        n_cmp++; if (sticky !== 1'b0) begin n_err++; $display("FAIL rst_sticky got %b exp 0", sticky); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", state); end
        n_cmp++; if (bus_q_valid !== 1'b0) begin n_err++; $display("FAIL rst_bus_q_valid got %b exp 0", bus_q_valid); end
        src_out = '0; clr_n = 1'b1;
        step();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rel_state got %0d exp 0", state); end
        n_cmp++; if (bus_out !== 32'h0) begin n_err++; $display("FAIL rel_bus_out got %h exp 0", bus_out); end
        n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL rel_cnt got %0d exp 0", cnt); end
    endtask

    task automatic test_single();
        src_out = '0; src_out[3] = 1'b1;
        #1;
        n_cmp++; if (bus_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_bus_out got %h exp deadbeef", bus_out); end
        n_cmp++; if (sel_idx !== 5'd3) begin n_err++; $display("FAIL single_sel_idx got %0d exp 3", sel_idx); end
        n_cmp++; if (sel_valid !== 1'b1) begin n_err++; $display("FAIL single_sel_valid got %b exp 1", sel_valid); end
        n_cmp++; if (conflict !== 1'b0) begin n_err++; $display("FAIL single_conflict got %b exp 0", conflict); end
        step();
        n_cmp++; if (bus_q !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_bus_q got %h exp deadbeef", bus_q); end
        n_cmp++; if (bus_q_valid !== 1'b1) begin n_err++; $display("FAIL single_bus_q_valid got %b exp 1", bus_q_valid); end
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL single_state got %0d exp 1", state); end
    endtask

    task automatic test_hold();
        src_out = '0;
        #1;
        n_cmp++; if (bus_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL hold_bus_out got %h exp deadbeef", bus_out); end
        n_cmp++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL hold_sel_valid got %b exp 0", sel_valid); end
        n_cmp++; if (sel_idx !== 5'd0) begin n_err++; $display("FAIL hold_sel_idx got %0d exp 0", sel_idx); end
        n_cmp++; if (n_bus_out !== 32'h0) begin n_err++; $display("FAIL nohold_bus_out got %h exp 0", n_bus_out); end
        step();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL hold_state got %0d exp 0", state); end
        n_cmp++; if (bus_q !== 32'hDEADBEEF) begin n_err++; $display("FAIL hold_bus_q got %h exp deadbeef", bus_q); end
        n_cmp++; if (bus_q_valid !== 1'b0) begin n_err++; $display("FAIL hold_bus_q_valid got %b exp 0", bus_q_valid); end
        n_cmp++; if (n_bus_q !== 32'h0) begin n_err++; $display("FAIL nohold_bus_q got %h exp 0", n_bus_q); end
    endtask

    task automatic test_conflict();
        src_out = '0; src_out[2] = 1'b1; src_out[20] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (bus_out !== 32'h1000_0014) begin n_err++; $display("FAIL conf_bus_out[%0d] got %h exp 10000014", c, bus_out); end
            n_cmp++; if (sel_idx !== 5'd20) begin n_err++; $display("FAIL conf_sel_idx[%0d] got %0d exp 20", c, sel_idx); end
            n_cmp++; if (conflict !== 1'b1) begin n_err++; $display("FAIL conf_flag[%0d] got %b exp 1", c, conflict); end
            step();
        end
        n_cmp++; if (cnt !== 8'd3) begin n_err++; $display("FAIL conf_cnt got %0d exp 3", cnt); end
        n_cmp++; if (sticky !== 1'b1) begin n_err++; $display("FAIL conf_sticky got %b exp 1", sticky); end
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL conf_state got %0d exp 2", state); end
        src_out = '0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL conf_clr_cnt got %0d exp 0", cnt); end
        n_cmp++; if (sticky !== 1'b0) begin n_err++; $display("FAIL conf_clr_sticky got %b exp 0", sticky); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL conf_clr_state got %0d exp 0", state); end
    endtask

    task automatic test_saturation();
        src_out = '0; src_out[0] = 1'b1; src_out[24] = 1'b1;
        for (int c = 0; c < 5; c++) step();
        n_cmp++; if (s_cnt !== 2'd3) begin n_err++; $display("FAIL sat_cnt got %0d exp 3", s_cnt); end
        n_cmp++; if (cnt !== 8'd5) begin n_err++; $display("FAIL wide_cnt got %0d exp 5", cnt); end
        n_cmp++; if (bus_q !== 32'h1000_0018) begin n_err++; $display("FAIL sat_bus_q got %h exp 10000018", bus_q); end
        err_clr = 1'b1;
        step();
        n_cmp++; if (s_cnt !== 2'd1) begin n_err++; $display("FAIL simul_cnt got %0d exp 1", s_cnt); end
        n_cmp++; if (s_sticky !== 1'b1) begin n_err++; $display("FAIL simul_sticky got %b exp 1", s_sticky); end
        n_cmp++; if (cnt !== 8'd1) begin n_err++; $display("FAIL simul_wide_cnt got %0d exp 1", cnt); end
        src_out = '0;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_owner_change();
        src_out = '0; src_out[5] = 1'b1;
        step();
        n_cmp++; if (owner_change !== 1'b0) begin n_err++; $display("FAIL oc_first got %b exp 0", owner_change); end
        src_out = '0; src_out[9] = 1'b1;
        step();
        n_cmp++; if (owner_change !== 1'b1) begin n_err++; $display("FAIL oc_pulse got %b exp 1", owner_change); end
        step();
        n_cmp++; if (owner_change !== 1'b0) begin n_err++; $display("FAIL oc_one_cycle got %b exp 0", owner_change); end
        src_out = '0;
        step();
        src_out[5] = 1'b1;
        step();
        n_cmp++; if (owner_change !== 1'b0) begin n_err++; $display("FAIL oc_after_idle_5 got %b exp 0", owner_change); end
        src_out = '0;
        step();
        src_out[9] = 1'b1;
        step();
        n_cmp++; if (owner_change !== 1'b0) begin n_err++; $display("FAIL oc_redrive got %b exp 0", owner_change); end
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL oc_state got %0d exp 1", state); end
    endtask

    task automatic test_reset_mid();
        src_out = '0; src_out[3] = 1'b1; src_out[7] = 1'b1;
        step();
        clr_n = 1'b0;
        step();
        src_out = '0;
        #1;
        n_cmp++; if (bus_out !== 32'h0) begin n_err++; $display("FAIL mid_bus_out got %h exp 0", bus_out); end
        n_cmp++; if (bus_q !== 32'h0) begin n_err++; $display("FAIL mid_bus_q got %h exp 0", bus_q); end
        n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL mid_cnt got %0d exp 0", cnt); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL mid_state got %0d exp 0", state); end
        clr_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N_SRC; i++) src_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
        src_data[3*WIDTH +: WIDTH] = 32'hDEADBEEF;
        clr_n = 1'b0; src_out = '0; err_clr = 1'b0;
        step();
        test_reset();
        test_single();
        test_hold();
        test_conflict();
        test_saturation();
        test_owner_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
